// File: rtl/butterfly_lane_ingress_ctrl.sv
// butterfly_lane_ingress_ctrl: splits the packed upstream complex stream into
// per-lane elastic FIFOs, frames it against a configured beat count, and
// double-buffers the broadcast butterfly coefficient set.
module butterfly_lane_ingress_ctrl #(
    parameter int unsigned data_width     = 16,
    parameter int unsigned num_lanes      = 4,
    parameter int unsigned bu_parallelism = 4,
    parameter int unsigned fifo_depth     = 4,
    parameter int unsigned len_width      = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    cfg_vld,
    input  logic [len_width-1:0]                    length,
    input  logic [num_lanes-1:0]                    lane_mask,
    input  logic [4*data_width*bu_parallelism-1:0]  coef_in,
    input  logic                                    coef_vld,
    input  logic                                    up_vld,
    input  logic [2*data_width*num_lanes-1:0]       up_dat,
    output logic                                    up_rdy,
    output logic [num_lanes-1:0]                    dn_vld,
    output logic [2*data_width*num_lanes-1:0]       dn_dat,
    output logic [num_lanes-1:0]                    dn_last,
    input  logic [num_lanes-1:0]                    dn_rdy,
    output logic [4*data_width*bu_parallelism-1:0]  coef_active,
    output logic                                    coef_active_vld,
    output logic                                    frame_start,
    output logic                                    frame_done,
    output logic                                    busy
);

    localparam int unsigned LANE_W = 2 * data_width;
    localparam int unsigned COEF_W = 4 * data_width * bu_parallelism;
    localparam int unsigned PTR_W  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // One FIFO entry: lane payload plus end-of-frame marker.
    typedef struct packed {
        logic              last;
        logic [LANE_W-1:0] data;
    } entry_t;

    state_e               state_q, state_d;
    logic [len_width-1:0] len_q, len_d;
    logic [len_width-1:0] beat_cnt_q, beat_cnt_d;
    logic [num_lanes-1:0] mask_q, mask_d;
    logic [COEF_W-1:0]    shadow_q, shadow_d;
    logic                 shadow_pending_q, shadow_pending_d;
    logic [COEF_W-1:0]    coef_active_q, coef_active_d;
    logic                 coef_active_vld_q, coef_active_vld_d;
    logic                 frame_start_q, frame_start_d;
    logic                 frame_done_q, frame_done_d;

    logic [num_lanes-1:0] fifo_full_c;
    logic [num_lanes-1:0] fifo_empty_c;
    logic                 all_empty_c;
    logic                 up_rdy_c;
    logic                 accept_c;
    logic                 push_last_c;

    // Drain completes once every enabled lane FIFO has emptied.
    assign all_empty_c = &(~mask_q | fifo_empty_c);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame configuration, beat counter, coefficient and event-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q             <= '0;
            beat_cnt_q        <= '0;
            mask_q            <= '0;
            shadow_q          <= '0;
            shadow_pending_q  <= 1'b0;
            coef_active_q     <= '0;
            coef_active_vld_q <= 1'b0;
            frame_start_q     <= 1'b0;
            frame_done_q      <= 1'b0;
        end else begin
            len_q             <= len_d;
            beat_cnt_q        <= beat_cnt_d;
            mask_q            <= mask_d;
            shadow_q          <= shadow_d;
            shadow_pending_q  <= shadow_pending_d;
            coef_active_q     <= coef_active_d;
            coef_active_vld_q <= coef_active_vld_d;
            frame_start_q     <= frame_start_d;
            frame_done_q      <= frame_done_d;
        end
    end

    // Next-state, upstream handshake and coefficient swap decisions.
    always_comb begin
        state_d           = state_q;
        len_d             = len_q;
        beat_cnt_d        = beat_cnt_q;
        mask_d            = mask_q;
        shadow_d          = shadow_q;
        shadow_pending_d  = shadow_pending_q;
        coef_active_d     = coef_active_q;
        coef_active_vld_d = 1'b0;
        frame_start_d     = 1'b0;
        frame_done_d      = 1'b0;
        up_rdy_c          = 1'b0;
        accept_c          = 1'b0;
        push_last_c       = 1'b0;

        // The swap below reads the old shadow, so a same-cycle load survives as pending.
        if (coef_vld) begin
            shadow_d         = coef_in;
            shadow_pending_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_vld && (length != '0)) begin
                    len_d         = length;
                    mask_d        = lane_mask;
                    beat_cnt_d    = '0;
                    frame_start_d = 1'b1;
                    state_d       = ST_RUN;
                    if (shadow_pending_q) begin
                        coef_active_d     = shadow_q;
                        coef_active_vld_d = 1'b1;
                        shadow_pending_d  = coef_vld;
                    end
                end
            end
            ST_RUN: begin
                up_rdy_c = &(~(mask_q & fifo_full_c));
                accept_c = up_vld && up_rdy_c;
                if (accept_c) begin
                    beat_cnt_d = beat_cnt_q + len_width'(1);
                    if (beat_cnt_q == (len_q - len_width'(1))) begin
                        push_last_c = 1'b1;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (all_empty_c) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-lane elastic FIFOs; full is taken from the count register only.
    for (genvar g = 0; g < num_lanes; g++) begin : g_lane
        entry_t           mem_q [fifo_depth];
        logic [PTR_W-1:0] wr_ptr_q;
        logic [PTR_W-1:0] rd_ptr_q;
        logic [CNT_W-1:0] cnt_q;
        logic             push_c;
        logic             pop_c;
        entry_t           wr_entry_c;
        entry_t           head_c;

        assign fifo_full_c[g]  = (cnt_q == CNT_W'(fifo_depth));
        assign fifo_empty_c[g] = (cnt_q == '0);
        assign push_c          = accept_c & mask_q[g];
        assign pop_c           = dn_vld[g] & dn_rdy[g];
        assign wr_entry_c      = {push_last_c, up_dat[g*LANE_W +: LANE_W]};
        assign head_c          = mem_q[rd_ptr_q];

        assign dn_vld[g]                   = ~fifo_empty_c[g] & mask_q[g];
        assign dn_last[g]                  = dn_vld[g] & head_c.last;
        assign dn_dat[g*LANE_W +: LANE_W]  = dn_vld[g] ? head_c.data : '0;

        // Pointer and occupancy tracking; pointers wrap naturally at the depth.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push_c) begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                end
                if (pop_c) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                cnt_q <= cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
            end
        end

        // Storage array; contents are masked at the output while empty.
        always_ff @(posedge clk) begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= wr_entry_c;
            end
        end
    end

    assign up_rdy          = up_rdy_c;
    assign coef_active     = coef_active_q;
    assign coef_active_vld = coef_active_vld_q;
    assign frame_start     = frame_start_q;
    assign frame_done      = frame_done_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_butterfly_lane_ingress_ctrl.sv
// Scoreboard bench for butterfly_lane_ingress_ctrl: accepted beats are queued
// per lane and compared when the lane hands them downstream.
module tb_butterfly_lane_ingress_ctrl;

    localparam int unsigned DW     = 16;
    localparam int unsigned NL     = 4;
    localparam int unsigned BP     = 4;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned LW     = 16;
    localparam int unsigned LANE_W = 2 * DW;
    localparam int unsigned BUS_W  = LANE_W * NL;
    localparam int unsigned COEF_W = 4 * DW * BP;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;

    localparam logic [COEF_W-1:0] COEF_A = {8{32'hA5A5_A5A5}};
    localparam logic [COEF_W-1:0] COEF_B = {8{32'hB00B_1234}};
    localparam logic [COEF_W-1:0] COEF_C = {8{32'hC0DE_5678}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_vld;
    logic [LW-1:0]     length;
    logic [NL-1:0]     lane_mask;
    logic [COEF_W-1:0] coef_in;
    logic              coef_vld;
    logic              up_vld;
    logic [BUS_W-1:0]  up_dat;
    logic              up_rdy;
    logic [NL-1:0]     dn_vld;
    logic [BUS_W-1:0]  dn_dat;
    logic [NL-1:0]     dn_last;
    logic [NL-1:0]     dn_rdy;
    logic [COEF_W-1:0] coef_active;
    logic              coef_active_vld;
    logic              frame_start;
    logic              frame_done;
    logic              busy;

    butterfly_lane_ingress_ctrl #(
        .data_width     (DW),
        .num_lanes      (NL),
        .bu_parallelism (BP),
        .fifo_depth     (DEPTH),
        .len_width      (LW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_vld         (cfg_vld),
        .length          (length),
        .lane_mask       (lane_mask),
        .coef_in         (coef_in),
        .coef_vld        (coef_vld),
        .up_vld          (up_vld),
        .up_dat          (up_dat),
        .up_rdy          (up_rdy),
        .dn_vld          (dn_vld),
        .dn_dat          (dn_dat),
        .dn_last         (dn_last),
        .dn_rdy          (dn_rdy),
        .coef_active     (coef_active),
        .coef_active_vld (coef_active_vld),
        .frame_start     (frame_start),
        .frame_done      (frame_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef logic [LANE_W:0] ent_t;

    ent_t              exp_q [NL][$];
    int                m_state;
    logic [LW-1:0]     m_len;
    logic [LW-1:0]     m_cnt;
    logic [NL-1:0]     m_mask;
    logic [COEF_W-1:0] m_shadow;
    logic [COEF_W-1:0] m_active;
    logic              m_pend;

    int n_vec   = 0;
    int n_err   = 0;
    int dut_acc = 0;
    int done_cnt = 0;

    task automatic check_eq(input string tag, input logic [COEF_W-1:0] act,
                            input logic [COEF_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic new_data();
        for (int i = 0; i < NL; i++) begin
            up_dat[i*LANE_W +: LANE_W] = LANE_W'($urandom());
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) exp_q[i].delete();
        m_state  = S_IDLE;
        m_len    = '0;
        m_cnt    = '0;
        m_mask   = '0;
        m_shadow = '0;
        m_active = '0;
        m_pend   = 1'b0;
    endtask

    // Asserts reset mid-cycle, checks outputs clear at once, releases away from the edge.
    task automatic reset_check(input string tag);
        #2 rst_n = 1'b0;
        #1;
        cfg_vld  = 1'b0;
        coef_vld = 1'b0;
        up_vld   = 1'b0;
        check_eq({tag, ".up_rdy"}, up_rdy, 0);
        check_eq({tag, ".dn_vld"}, dn_vld, 0);
        check_eq({tag, ".dn_dat"}, dn_dat, 0);
        check_eq({tag, ".dn_last"}, dn_last, 0);
        check_eq({tag, ".busy"}, busy, 0);
        check_eq({tag, ".frame_start"}, frame_start, 0);
        check_eq({tag, ".frame_done"}, frame_done, 0);
        check_eq({tag, ".coef_active_vld"}, coef_active_vld, 0);
        check_eq({tag, ".coef_active"}, coef_active, 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: compare pre-edge handshakes/heads, advance the model, compare pulses.
    task automatic tick();
        logic exp_rdy;
        logic drained;
        logic last;
        logic e_fs;
        logic e_fd;
        logic e_cv;
        int   nstate;
        ent_t head;

        exp_rdy = (m_state == S_RUN);
        for (int i = 0; i < NL; i++) begin
            if (m_mask[i] && (exp_q[i].size() >= DEPTH)) exp_rdy = 1'b0;
        end
        check_eq("up_rdy", up_rdy, exp_rdy);
        if (up_vld && up_rdy) dut_acc++;

        drained = 1'b1;
        for (int i = 0; i < NL; i++) begin
            if (exp_q[i].size() != 0) drained = 1'b0;
        end

        for (int i = 0; i < NL; i++) begin
            check_eq($sformatf("dn_vld[%0d]", i), dn_vld[i], exp_q[i].size() != 0);
            if (exp_q[i].size() != 0) begin
                head = exp_q[i][0];
                check_eq($sformatf("dn_dat[%0d]", i), dn_dat[i*LANE_W +: LANE_W], head[LANE_W-1:0]);
                check_eq($sformatf("dn_last[%0d]", i), dn_last[i], head[LANE_W]);
                if (dn_rdy[i]) void'(exp_q[i].pop_front());
            end else begin
                check_eq($sformatf("dn_dat_empty[%0d]", i), dn_dat[i*LANE_W +: LANE_W], 0);
                check_eq($sformatf("dn_last_empty[%0d]", i), dn_last[i], 0);
            end
        end

        nstate = m_state;
        e_fs   = 1'b0;
        e_fd   = 1'b0;
        e_cv   = 1'b0;
        case (m_state)
            S_IDLE: begin
                if (cfg_vld && (length != 0)) begin
                    m_len   = length;
                    m_mask  = lane_mask;
                    m_cnt   = '0;
                    nstate  = S_RUN;
                    e_fs    = 1'b1;
                    if (m_pend) begin
                        m_active = m_shadow;
                        e_cv     = 1'b1;
                        m_pend   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                if (up_vld && exp_rdy) begin
                    last = (m_cnt == m_len - LW'(1));
                    for (int i = 0; i < NL; i++) begin
                        if (m_mask[i]) exp_q[i].push_back({last, up_dat[i*LANE_W +: LANE_W]});
                    end
                    m_cnt = m_cnt + LW'(1);
                    if (last) nstate = S_DRAIN;
                end
            end
            default: begin
                if (drained) begin
                    e_fd   = 1'b1;
                    nstate = S_IDLE;
                end
            end
        endcase
        if (coef_vld) begin
            m_shadow = coef_in;
            m_pend   = 1'b1;
        end
        m_state = nstate;

        @(posedge clk);
        #1;
        check_eq("frame_start", frame_start, e_fs);
        check_eq("frame_done", frame_done, e_fd);
        check_eq("coef_active_vld", coef_active_vld, e_cv);
        check_eq("busy", busy, nstate != S_IDLE);
        check_eq("coef_active", coef_active, m_active);
        if (frame_done) done_cnt++;
        new_data();
    endtask

    task automatic cfg(input int len, input logic [NL-1:0] m);
        cfg_vld   = 1'b1;
        length    = LW'(len);
        lane_mask = m;
        tick();
        cfg_vld   = 1'b0;
    endtask

    task automatic run_to_idle();
        int n;
        n = 0;
        while ((m_state != S_IDLE) && (n < 400)) begin
            tick();
            n++;
        end
        up_vld = 1'b0;
        check_eq("idle_after_frame", busy, 0);
    endtask

    initial begin
        rst_n     = 1'b1;
        cfg_vld   = 1'b0;
        length    = '0;
        lane_mask = '0;
        coef_in   = '0;
        coef_vld  = 1'b0;
        up_vld    = 1'b0;
        up_dat    = '0;
        dn_rdy    = '0;
        model_reset();
        #1;
        reset_check("por");
        new_data();

        // Basic frame with first coefficient swap.
        coef_in = COEF_A; coef_vld = 1'b1; tick(); coef_vld = 1'b0;
        dn_rdy = 4'b1111; done_cnt = 0;
        cfg(8, 4'b1111);
        up_vld = 1'b1;
        run_to_idle();
        check_eq("basic.coef", coef_active, COEF_A);
        check_eq("basic.done_cnt", done_cnt, 1);

        // Backpressure: lane 0 stalls, FIFO fills after DEPTH beats.
        dn_rdy = 4'b1110; dut_acc = 0; done_cnt = 0;
        cfg(8, 4'b0101);
        up_vld = 1'b1;
        repeat (8) tick();
        check_eq("bp.accepted", dut_acc, DEPTH);
        dn_rdy = 4'b1111;
        run_to_idle();
        check_eq("bp.accepted_total", dut_acc, 8);
        check_eq("bp.done_cnt", done_cnt, 1);

        // Independent drain: lanes 2/3 hold the frame open.
        dn_rdy = 4'b0011; done_cnt = 0;
        cfg(4, 4'b1111);
        up_vld = 1'b1;
        repeat (10) tick();
        up_vld = 1'b0;
        check_eq("drain.busy_held", busy, 1);
        check_eq("drain.no_done", done_cnt, 0);
        dn_rdy = 4'b1111;
        run_to_idle();
        check_eq("drain.done_cnt", done_cnt, 1);

        // Coefficient load mid-frame stays in shadow.
        cfg(4, 4'b1111);
        coef_in = COEF_B; coef_vld = 1'b1; tick(); coef_vld = 1'b0;
        up_vld = 1'b1;
        run_to_idle();
        check_eq("coef.hold_A", coef_active, COEF_A);

        // Load on acceptance cycle; cfg held during RUN is ignored.
        coef_in = COEF_C; coef_vld = 1'b1;
        cfg(2, 4'b1111);
        coef_vld = 1'b0;
        check_eq("coef.swap_B", coef_active, COEF_B);
        cfg_vld = 1'b1; length = LW'(5); lane_mask = 4'b0001;
        up_vld = 1'b1;
        run_to_idle();
        cfg_vld = 1'b0;

        // Length 1 frame picks up the still-pending set.
        cfg(1, 4'b1111);
        check_eq("coef.swap_C", coef_active, COEF_C);
        up_vld = 1'b1;
        run_to_idle();

        // Length 0 is ignored.
        done_cnt = 0;
        cfg(0, 4'b1111);
        check_eq("len0.idle", busy, 0);
        repeat (2) tick();

        // Empty mask: beats counted and dropped.
        cfg(3, 4'b0000);
        up_vld = 1'b1;
        run_to_idle();
        check_eq("mask0.done_cnt", done_cnt, 1);

        // Reset in the middle of a frame.
        dn_rdy = 4'b0000;
        cfg(8, 4'b1111);
        up_vld = 1'b1;
        repeat (3) tick();
        reset_check("mid");
        dn_rdy = 4'b1111;
        repeat (3) tick();
        check_eq("mid.dn_vld", dn_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/butterfly_lane_ingress_ctrl.md
Name: butterfly_lane_ingress_ctrl

Overview:
- Parametrised multi-lane ingress and frame controller for the butterfly engine array. It sits between the upstream packed complex stream and num_lanes butterfly engine lanes.
- Splits each packed beat into per-lane elastic FIFOs and honours a per-frame lane mask. Counts beats against a frame length and raises frame start/done events.
- Double-buffers the broadcast butterfly coefficients so a new coefficient set can load during a running frame without disturbing it.

Parameters:
- data_width, 16, width of one real or imaginary component
- num_lanes, 4, number of engine lanes fed
- bu_parallelism, 4, butterfly units per lane (sizes the coefficient word)
- fifo_depth, 4, entries per lane FIFO; power of 2, >=2
- len_width, 16, width of the frame length and beat counter

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_vld  in  1  frame configuration strobe
- length  in  len_width  beats in the frame; 0 is illegal and ignored
- lane_mask  in  num_lanes  bit i=1 enables lane i for the frame
- coef_in  in  4*data_width*bu_parallelism  incoming coefficient set
- coef_vld  in  1  coef_in valid, loads the shadow register
- up_vld  in  1  upstream beat valid
- up_dat  in  2*data_width*num_lanes  lane i occupies bits [2*data_width*i +: 2*data_width] (real high, imaginary low)
- up_rdy  out  1  beat accepted when up_vld&&up_rdy
- dn_vld  out  num_lanes  per-lane output valid
- dn_dat  out  2*data_width*num_lanes  per-lane output data, same packing as up_dat
- dn_last  out  num_lanes  marks the final beat of the frame on lane i
- dn_rdy  in  num_lanes  per-lane downstream ready
- coef_active  out  4*data_width*bu_parallelism  coefficient set in use by the lanes
- coef_active_vld  out  1  one-cycle pulse when coef_active changes
- frame_start  out  1  one-cycle pulse on frame acceptance
- frame_done  out  1  one-cycle pulse when the frame has fully drained
- busy  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; FIFOs empty; beat_cnt=0; latched mask=0; shadow_pending=0.
  - All outputs 0, including coef_active.
- FSM IDLE:
  - up_rdy=0.
  - cfg_vld=1 with length!=0: latch length and lane_mask, clear beat_cnt, go to RUN. frame_start pulses in the cycle after acceptance, the first RUN cycle.
  - cfg_vld with length==0: ignored, stay IDLE, no pulse.
  - cfg_vld with lane_mask==0: accepted; beats are counted and dropped.
- FSM RUN:
  - up_rdy = AND over enabled lanes of !fifo_full[i]; 1 if no lane is enabled.
  - Accept: push up_dat lane i into FIFO i for each enabled lane, together with a last flag; beat_cnt++.
  - Accept with beat_cnt==length-1: last flag=1, go to DRAIN.
  - cfg_vld in RUN or DRAIN is ignored.
- FSM DRAIN:
  - up_rdy=0.
  - When all enabled FIFOs are empty: frame_done pulses for one cycle, go to IDLE. busy drops in the same cycle frame_done is asserted. In that cycle, frame_done=1 and busy=0.
- Lane output:
  - dn_vld[i] = FIFO i non-empty; dn_dat and dn_last come from the FIFO head.
  - Pop on dn_vld[i]&&dn_rdy[i]; lanes advance independently.
  - Masked lanes hold dn_vld=0, dn_dat=0, dn_last=0.
  - Latency: a beat accepted in cycle N is visible on dn_* in cycle N+1.
- Full boundary:
  - up_rdy uses the registered full flag only. A pop in the same cycle does not allow a push into a full FIFO.
  - No overflow or underflow is possible; pointers wrap modulo fifo_depth.
  - Count width is log2(fifo_depth)+1.
- Coefficients:
  - coef_vld loads the shadow register and sets shadow_pending, in any state.
  - On cfg acceptance with shadow_pending=1: coef_active<=shadow, shadow_pending cleared. coef_active_vld pulses on the same cycle as frame_start.
  - coef_vld in the same cycle as acceptance: the swap uses the old shadow; the new value loads into the shadow and shadow_pending stays 1.
  - coef_active never changes during RUN or DRAIN.
- Reset mid-frame: immediate return to the reset state. FIFO contents are discarded and no frame_done is generated.

Test Plan:
- Basic frame. Reset; coef_vld with coef_in=0xA5..; cfg with length=8, mask=4'b1111; 8 beats, dn_rdy=1111.
  - frame_start and coef_active_vld pulse together.
  - Each lane outputs 8 beats in order, one cycle after acceptance; dn_last on beat 8.
  - frame_done pulses once all FIFOs are empty.
- Backpressure. fifo_depth=4, mask=0101, dn_rdy[0]=0, up_vld held high.
  - up_rdy drops after 4 accepted beats.
  - Releasing dn_rdy[0] resumes acceptance.
  - Lanes 1 and 3 keep dn_vld=0 and dn_dat=0.
- Independent drain. dn_rdy=0011 for 10 cycles, then 1111.
  - frame_done is withheld until lanes 2 and 3 are empty, then pulses exactly once.
  - dn_last appears per lane on beat length.
- Coefficient double-buffer.
  - coef_vld=B during a RUN frame: coef_active stays A until the next cfg acceptance, then becomes B.
  - coef_vld=C on the acceptance cycle: swap to B, pending stays set; the next frame swaps to C.
- Config edge cases.
  - cfg with length=0: no frame_start, stays IDLE.
  - cfg with length=1: single beat carrying dn_last.
  - cfg during RUN: ignored.
  - rst_n low mid-frame: all outputs 0 asynchronously, FIFOs empty after release.
